mem_stage: RTL

Memory-access stage of the 5-stage pipelined CPU, between the EX/MEM pipeline register and the WB stage. Non-memory instructions pass through in the same cycle. Loads and stores run a multi-cycle request/acknowledge transaction on the data-memory port and stall upstream until it completes. Load data is aligned and sign/zero-extended. Outputs are sampled by WB every rising edge as MemResult/MemRegWrite/MemRd.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_load_align.sv | 34 +++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states
// and access-size helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Unsupported encodings (011, 110, 111) fall into the word class.
  function automatic logic [1:0] acc_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: picks the addressed byte/half out of the read word and
// sign- or zero-extends it according to funct3.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_result = {24'h000000, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_HU:   o_result = {16'h0000, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: ALU results pass straight through; loads/stores run a
// req/ack data-memory transaction while stalling upstream.
// Optional build macro MEM_MISALIGN_TRAP_EN: trap misaligned H/W accesses
// instead of silently aligning them.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ExValid,
  input  logic [31:0] ExAluResult,
  input  logic [31:0] ExStoreData,
  input  logic [4:0]  ExRd,
  input  logic        ExRegWrite,
  input  logic        ExMemRead,
  input  logic        ExMemWrite,
  input  logic [2:0]  ExFunct3,
  output logic        DmemReq,
  output logic        DmemWe,
  output logic [31:0] DmemAddr,
  output logic [31:0] DmemWdata,
  output logic [3:0]  DmemBe,
  input  logic [31:0] DmemRdata,
  input  logic        DmemAck,
  output logic [31:0] MemResult,
  output logic        MemRegWrite,
  output logic [4:0]  MemRd,
  output logic        MemStall,
  output logic        MemMisalign,
  output logic [1:0]  DbgState
);

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_result;
  logic [3:0]  r_be;
  logic        r_we, r_regwrite, r_misalign;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;

  logic        w_memop, w_mis;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_load_data;
  logic [3:0]  w_be;

  assign w_memop = ExValid && (ExMemRead || ExMemWrite);

  always_comb begin
    w_size = acc_size(ExFunct3);
    w_addr = ExAluResult;
`ifdef MEM_MISALIGN_TRAP_EN
    w_mis = ((w_size == SZ_H) && ExAluResult[0]) ||
            ((w_size == SZ_W) && (ExAluResult[1:0] != 2'b00));
`else
    w_mis = 1'b0;
    if (w_size == SZ_H)      w_addr[0]   = 1'b0;
    else if (w_size == SZ_W) w_addr[1:0] = 2'b00;
`endif
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{ExStoreData[7:0]}};
      end
      SZ_H: begin
        w_be    = 4'b0011 << {w_addr[1], 1'b0};
        w_wdata = {2{ExStoreData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = ExStoreData;
      end
    endcase
  end

  mem_load_align u_align (
    .i_rdata  (DmemRdata),
    .i_addr   (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_result (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_we       <= 1'b0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_result   <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_memop) begin
        r_addr     <= w_addr;
        r_wdata    <= w_wdata;
        r_be       <= w_be;
        r_we       <= ExMemWrite && !ExMemRead;
        r_funct3   <= ExFunct3;
        r_rd       <= ExRd;
        r_regwrite <= ExRegWrite;
        r_result   <= '0;
        r_misalign <= w_mis;
      end
      if (r_state == S_ACCESS && DmemAck && !r_we) r_result <= w_load_data;
    end
  end

  // Outputs are forced to zero while reset is high, including the
  // combinational pass-through path.
  always_comb begin
    w_next      = r_state;
    DmemReq     = 1'b0;
    MemResult   = '0;
    MemRd       = '0;
    MemRegWrite = 1'b0;
    MemStall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          MemStall = 1'b1;
          w_next   = w_mis ? S_DONE : S_ACCESS;
        end else if (ExValid) begin
          MemResult   = ExAluResult;
          MemRd       = ExRd;
          MemRegWrite = ExRegWrite;
        end
      end
      S_ACCESS: begin
        DmemReq  = 1'b1;
        MemStall = 1'b1;
        if (DmemAck) w_next = S_DONE;
      end
      S_DONE: begin
        MemResult   = r_result;
        MemRd       = r_rd;
        MemRegWrite = r_regwrite && !r_we && !r_misalign;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      DmemReq     = 1'b0;
      MemResult   = '0;
      MemRd       = '0;
      MemRegWrite = 1'b0;
      MemStall    = 1'b0;
    end
  end

  assign DmemWe    = r_we;
  assign DmemAddr  = {r_addr[31:2], 2'b00};
  assign DmemWdata = r_wdata;
  assign DmemBe    = r_be;
  assign DbgState  = r_state;

`ifdef MEM_MISALIGN_TRAP_EN
  assign MemMisalign = (r_state == S_DONE) && r_misalign;
`else
  assign MemMisalign = 1'b0;
`endif

endmodule
